// File: rtl/peripheral_adder_pkg.sv
// Shared types and width helpers for the streaming peripheral adder.
package peripheral_adder_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_ACC  = 2'b10,
        OP_LOAD = 2'b11
    } adder_op_t;

    function automatic int calc_out_width(input int data_width, input int guard_bits);
        return data_width + guard_bits;
    endfunction

endpackage

// File: rtl/peripheral_adder_fifo.sv
// Result buffer: power-of-two depth FIFO with true occupancy count, synchronous active-low reset.
module peripheral_adder_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4,
    localparam int ADDR_WIDTH = $clog2(DEPTH),
    localparam int LEVEL_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [LEVEL_WIDTH-1:0] level
);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (level == LEVEL_WIDTH'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Head reads as zero when empty so the output is clean after reset.
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/peripheral_adder_stream.sv
// Streaming add/sub/accumulate unit with buffered results.
// Optional macro PERIPHERAL_ADDER_SATURATE_EN clamps SUB and ACC instead of wrapping.
module peripheral_adder_stream
    import peripheral_adder_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int GUARD_BITS = 4,
    parameter int FIFO_DEPTH = 4,
    localparam int OUT_WIDTH = calc_out_width(DATA_WIDTH, GUARD_BITS),
    localparam int LEVEL_WIDTH = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  in1,
    input  logic [DATA_WIDTH-1:0]  in2,
    input  logic [1:0]             op,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [OUT_WIDTH-1:0]   out,
    output logic                   out_flag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LEVEL_WIDTH-1:0] level
);

    adder_op_t            op_e;
    logic [OUT_WIDTH-1:0] acc;
    logic [OUT_WIDTH-1:0] acc_next;
    logic [OUT_WIDTH-1:0] result;
    logic                 flag;
    logic [OUT_WIDTH:0]   a_ext;
    logic [OUT_WIDTH:0]   b_ext;
    logic [OUT_WIDTH:0]   wide;
    logic                 accept;
    logic                 full;
    logic                 empty;

    assign in_ready  = rst && !full;
    assign accept    = in_valid && in_ready;
    assign out_valid = !empty;

    // One extra bit on the arithmetic carries the carry/borrow into the flag.
    always_comb begin
        op_e     = adder_op_t'(op);
        a_ext    = (OUT_WIDTH+1)'(in1);
        b_ext    = (OUT_WIDTH+1)'(in2);
        wide     = '0;
        result   = '0;
        flag     = 1'b0;
        acc_next = acc;
        case (op_e)
            OP_ADD: begin
                wide   = a_ext + b_ext;
                result = wide[OUT_WIDTH-1:0];
                flag   = wide[OUT_WIDTH];
            end
            OP_SUB: begin
                wide   = a_ext - b_ext;
                result = wide[OUT_WIDTH-1:0];
                flag   = wide[OUT_WIDTH];
`ifdef PERIPHERAL_ADDER_SATURATE_EN
                if (flag) begin
                    result = '0;
                end
`endif
            end
            OP_ACC: begin
                wide   = {1'b0, acc} + a_ext;
                result = wide[OUT_WIDTH-1:0];
                flag   = wide[OUT_WIDTH];
`ifdef PERIPHERAL_ADDER_SATURATE_EN
                if (flag) begin
                    result = '1;
                end
`endif
                acc_next = result;
            end
            OP_LOAD: begin
                result   = a_ext[OUT_WIDTH-1:0];
                acc_next = result;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc <= '0;
        end else if (accept) begin
            acc <= acc_next;
        end
    end

    peripheral_adder_fifo #(
        .WIDTH(OUT_WIDTH + 1),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (out_valid && out_ready),
        .wdata ({flag, result}),
        .rdata ({out_flag, out}),
        .full  (full),
        .empty (empty),
        .level (level)
    );

endmodule

// File: tb/tb_peripheral_adder_stream.sv
// Directed bench for peripheral_adder_stream (DATA_WIDTH=8, GUARD_BITS=1, FIFO_DEPTH=4).
module tb_peripheral_adder_stream;
    import peripheral_adder_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] in1;
    logic [7:0] in2;
    logic [1:0] op;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] out;
    logic       out_flag;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] level;

    int checks;
    int failures;

    peripheral_adder_stream #(
        .DATA_WIDTH(8),
        .GUARD_BITS(1),
        .FIFO_DEPTH(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in1       (in1),
        .in2       (in2),
        .op        (op),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_flag  (out_flag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair for exactly one edge, then withdraw it.
    task automatic applyStimulus(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
        op       = o;
        in1      = a;
        in2      = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        in1       = '0;
        in2       = '0;
        op        = OP_ADD;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        checkOutput("reset_level", 32'(level), 0);
        checkOutput("reset_valid", 32'(out_valid), 0);
        checkOutput("reset_out", 32'(out), 0);
        checkOutput("reset_flag", 32'(out_flag), 0);
        checkOutput("reset_in_ready", 32'(in_ready), 0);
        rst = 1'b1;
        #1;
        checkOutput("ready_after_reset", 32'(in_ready), 1);

        out_ready = 1'b1;
        applyStimulus(OP_ADD, 8'd5, 8'd2);
        checkOutput("add_out", 32'(out), 32'h007);
        checkOutput("add_flag", 32'(out_flag), 0);
        checkOutput("add_valid", 32'(out_valid), 1);
        step();
        checkOutput("add_valid_gone", 32'(out_valid), 0);
        checkOutput("add_level_gone", 32'(level), 0);

        applyStimulus(OP_ADD, 8'd255, 8'd255);
        checkOutput("add_max_out", 32'(out), 32'h1FE);
        checkOutput("add_max_flag", 32'(out_flag), 0);
        step();

        applyStimulus(OP_SUB, 8'd2, 8'd5);
`ifdef PERIPHERAL_ADDER_SATURATE_EN
        checkOutput("sub_out", 32'(out), 32'h000);
`else
        checkOutput("sub_out", 32'(out), 32'h1FD);
`endif
        checkOutput("sub_flag", 32'(out_flag), 1);
        step();

        applyStimulus(OP_LOAD, 8'd200, 8'd7);
        checkOutput("load_out", 32'(out), 200);
        checkOutput("load_flag", 32'(out_flag), 0);
        step();
        applyStimulus(OP_ACC, 8'd200, 8'd0);
        checkOutput("acc1_out", 32'(out), 32'h190);
        checkOutput("acc1_flag", 32'(out_flag), 0);
        step();
        applyStimulus(OP_ACC, 8'd200, 8'd0);
`ifdef PERIPHERAL_ADDER_SATURATE_EN
        checkOutput("acc2_out", 32'(out), 511);
`else
        checkOutput("acc2_out", 32'(out), 88);
`endif
        checkOutput("acc2_flag", 32'(out_flag), 1);
        step();

        applyStimulus(OP_LOAD, 8'd10, 8'd0);
        step();
        applyStimulus(OP_ADD, 8'd1, 8'd1);
        step();
        applyStimulus(OP_SUB, 8'd9, 8'd3);
        step();
        applyStimulus(OP_ACC, 8'd5, 8'd0);
        checkOutput("acc_untouched_by_add_sub", 32'(out), 15);
        step();

        // Stalled consumer: four accepted, fifth refused.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            op       = OP_ADD;
            in1      = 8'(i * 10 + 1);
            in2      = 8'(i);
            in_valid = 1'b1;
            #1;
            checkOutput($sformatf("bp_in_ready_%0d", i), 32'(in_ready), (i < 4) ? 1 : 0);
            step();
        end
        in_valid = 1'b0;
        checkOutput("bp_level_full", 32'(level), 4);
        checkOutput("bp_in_ready_low", 32'(in_ready), 0);
        checkOutput("bp_head_held", 32'(out), 1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("drain_valid_%0d", i), 32'(out_valid), 1);
            checkOutput($sformatf("drain_out_%0d", i), 32'(out), 32'(i * 11 + 1));
            step();
        end
        checkOutput("drain_level", 32'(level), 0);
        checkOutput("drain_valid_end", 32'(out_valid), 0);

        // Push and pop together at level 2, then pop-only at level 4.
        out_ready = 1'b0;
        applyStimulus(OP_ADD, 8'd1, 8'd1);
        applyStimulus(OP_ADD, 8'd2, 8'd2);
        checkOutput("sim_level2", 32'(level), 2);
        out_ready = 1'b1;
        applyStimulus(OP_ADD, 8'd3, 8'd3);
        out_ready = 1'b0;
        checkOutput("sim_level_kept", 32'(level), 2);
        checkOutput("sim_head", 32'(out), 4);
        applyStimulus(OP_ADD, 8'd5, 8'd5);
        applyStimulus(OP_ADD, 8'd7, 8'd7);
        checkOutput("sim_level4", 32'(level), 4);
        op        = OP_ADD;
        in1       = 8'd100;
        in2       = 8'd100;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        checkOutput("sim_full_in_ready", 32'(in_ready), 0);
        step();
        in_valid = 1'b0;
        checkOutput("sim_full_no_push", 32'(level), 3);
        checkOutput("sim_tail_0", 32'(out), 6);
        step();
        checkOutput("sim_tail_1", 32'(out), 10);
        step();
        checkOutput("sim_tail_2", 32'(out), 14);
        step();
        checkOutput("sim_tail_empty", 32'(out_valid), 0);

        // Reset with three buffered results and acc=123.
        out_ready = 1'b0;
        applyStimulus(OP_LOAD, 8'd123, 8'd0);
        applyStimulus(OP_ADD, 8'd1, 8'd2);
        applyStimulus(OP_ADD, 8'd3, 8'd4);
        checkOutput("mid_level3", 32'(level), 3);
        rst      = 1'b0;
        op       = OP_ACC;
        in1      = 8'd1;
        in_valid = 1'b1;
        #1;
        checkOutput("mid_in_ready_rst", 32'(in_ready), 0);
        step();
        checkOutput("mid_level0", 32'(level), 0);
        checkOutput("mid_valid0", 32'(out_valid), 0);
        checkOutput("mid_in_ready_held", 32'(in_ready), 0);
        rst      = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        applyStimulus(OP_ACC, 8'd1, 8'd0);
        checkOutput("mid_acc_cleared", 32'(out), 1);
        checkOutput("mid_acc_flag", 32'(out_flag), 0);
        checkOutput("mid_acc_level", 32'(level), 1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/peripheral_adder_stream.md
Name: peripheral_adder_stream

Overview:
Parametrised streaming successor to the fixed 8-bit registered adder. It accepts operand pairs over a valid/ready handshake and supports four modes: add, subtract, accumulate and accumulate-load. Results, each with a status flag, are buffered in an internal FIFO so that a stalled consumer does not drop data. It sits on the peripheral datapath between a register/bus front-end and a downstream consumer.

Parameters:
- DATA_WIDTH, 8: operand width in bits.
- GUARD_BITS, 4: extra result bits. OUT_WIDTH = DATA_WIDTH + GUARD_BITS (must be >= 1).
- FIFO_DEPTH, 4: result buffer entries; power of 2, >= 2.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset.
- in1  input  DATA_WIDTH  operand A (unsigned).
- in2  input  DATA_WIDTH  operand B (unsigned; ignored in ACC/LOAD).
- op  input  2  mode: 00 ADD, 01 SUB, 10 ACC, 11 LOAD.
- in_valid  input  1  operands/op valid.
- in_ready  output  1  block can accept.
- out  output  OUT_WIDTH  FIFO head result.
- out_flag  output  1  FIFO head status flag.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts head.
- level  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Interface (already decided):
- One clock; reset is synchronous and active-low.
- Clock port is clk, reset port is rst; rst = 0 sampled at a rising edge resets the block.

Behaviour:
- Reset (rst low at edge):
  - FIFO emptied, level = 0, out_valid = 0, out = 0, out_flag = 0.
  - Accumulator = 0.
  - in_ready = 0 while rst is low.
  - Applies mid-transfer: buffered results are discarded and no accept occurs on that edge.
- Accept: in_valid && in_ready at an edge. in_ready = (level < FIFO_DEPTH), combinational from level only.
- Pop: out_valid && out_ready at an edge; head advances.
- Latency: accepted result is visible at out/out_valid on the edge after accept (1 cycle) when the FIFO was empty. Otherwise ordering is strict FIFO.
- Simultaneous push and pop: both occur and level is unchanged.
  - When level == FIFO_DEPTH, in_ready = 0 and no push occurs, even if a pop happens that cycle (no bypass).
- Pointers wrap modulo FIFO_DEPTH. level is the true count 0..FIFO_DEPTH.
- ADD: result = zext(in1) + zext(in2); flag = carry out of OUT_WIDTH (0 whenever GUARD_BITS >= 1).
- SUB: result = zext(in1) - zext(in2), modulo 2^OUT_WIDTH; flag = borrow (in1 < in2).
- ACC: acc_next = acc + zext(in1), modulo 2^OUT_WIDTH; result = acc_next; flag = carry out; acc <= acc_next.
- LOAD: acc <= zext(in1); result = zext(in1); flag = 0.
- Accumulator timing:
  - Updates only on accept.
  - Not affected by pops or stalls.
  - ADD and SUB do not modify it.
- While out_valid = 1 and out_ready = 0, out and out_flag are held stable.
- No combinational path from in_valid or operands to any output.

Optional Feature:
- Macro PERIPHERAL_ADDER_SATURATE_EN.
- Defined:
  - ACC clamps to 2^OUT_WIDTH-1 on carry, with flag = 1 and acc held at max.
  - SUB clamps to 0 on borrow, with flag = 1.
  - ADD is unchanged.
- Undefined: wrap-around arithmetic as above; flag reports carry/borrow.

Decomposition:
- Package peripheral_adder_pkg:
  - typedef enum logic [1:0] adder_op_t {OP_ADD, OP_SUB, OP_ACC, OP_LOAD}.
  - Function for OUT_WIDTH derivation.
- Sub-module peripheral_adder_fifo:
  - Parametrised width (OUT_WIDTH+1) and depth.
  - Provides push/pop/full/empty/level, with the same clk/rst convention.
- Top level holds the op decode, accumulator and arithmetic.

Test Plan (DATA_WIDTH=8, GUARD_BITS=1, FIFO_DEPTH=4 unless stated):
- ADD: in1=5, in2=2, op=ADD, out_ready=1 -> next cycle out=9'h007, out_flag=0, out_valid=1 for one cycle. Repeat with 255+255 -> out=9'h1FE.
- SUB: 2-5 -> out=9'h1FD, out_flag=1. With SATURATE_EN: out=0, out_flag=1.
- ACC: LOAD 200, then ACC 200, then ACC 200 -> results 200, 400 (9'h190), then 600 mod 512 = 88 with out_flag=1. With SATURATE_EN the third result is 511, flag=1.
- Back-pressure: out_ready=0, push 5 ADDs -> in_ready drops after 4 accepts with level=4. Then raise out_ready -> results drain in order; no loss or duplicates; level returns to 0.
- Simultaneous traffic:
  - level=2 with push and pop in the same cycle -> level stays 2.
  - level=4 with pop and in_valid -> no push that cycle.
- Reset mid-stream: level=3 and acc=123, rst low for 1 cycle -> out_valid=0, level=0, in_ready=0 during reset. Then ACC 1 -> result 1.
